// File: rtl/c_tile_reader_if.sv
// Control, C SRAM read port and output element stream of the C tile reader.
// The reader takes the master modport; the surrounding logic takes the slave modport.
interface c_tile_reader_if #(
   parameter int M      = 8,
   parameter int N      = 8,
   parameter int DATA_W = 32,
   parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
   parameter int COL_W  = (N <= 1) ? 1 : $clog2(N)
);
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              c_re;
   logic [ROW_W-1:0]  c_rrow;
   logic [COL_W-1:0]  c_rcol;
   logic [DATA_W-1:0] c_rdata;
   // Stream handshake: an element transfers on every cycle where out_valid && out_ready.
   // While out_valid && !out_ready, out_data/out_row/out_col/out_eol/out_last hold and
   // out_valid stays high; only abort or reset may withdraw an offered element.
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ROW_W-1:0]  out_row;
   logic [COL_W-1:0]  out_col;
   logic              out_eol;
   logic              out_last;

   modport master (
      input  start, abort, c_rdata, out_ready,
      output busy, done, c_re, c_rrow, c_rcol,
             out_valid, out_data, out_row, out_col, out_eol, out_last
   );

   modport slave (
      output start, abort, c_rdata, out_ready,
      input  busy, done, c_re, c_rrow, c_rcol,
             out_valid, out_data, out_row, out_col, out_eol, out_last
   );
endinterface

// File: rtl/c_tile_reader.sv
// Streams an M x N C tile out of C SRAM in row-major order; a credit check on the
// FIFO absorbs the 1-cycle SRAM read latency so backpressure never drops an element.
module c_tile_reader #(
   parameter int M          = 8,
   parameter int N          = 8,
   parameter int DATA_W     = 32,
   parameter int ROW_W      = (M <= 1) ? 1 : $clog2(M),
   parameter int COL_W      = (N <= 1) ? 1 : $clog2(N),
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   c_tile_reader_if.master    bus_io,
   output logic [1:0]         state_o
);
   localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W = CNT_W + 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  rd_row_q, rd_row_d;
   logic [COL_W-1:0]  rd_col_q, rd_col_d;
   logic [ROW_W-1:0]  pend_row_q;
   logic [COL_W-1:0]  pend_col_q;
   logic              inflight_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [ROW_W-1:0]  fifo_row_q  [FIFO_DEPTH];
   logic [COL_W-1:0]  fifo_col_q  [FIFO_DEPTH];

   logic              empty, push, pop, issue, last_addr;
   logic [CRD_W-1:0]  credit_used;
   logic [ROW_W-1:0]  head_row;
   logic [COL_W-1:0]  head_col;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      empty       = (occ_q == '0);
      pop         = !empty && bus_io.out_ready;
      // A return arriving in the abort cycle belongs to the cancelled tile.
      push        = inflight_q && !bus_io.abort;
      occ_d       = occ_q + CNT_W'(push) - CNT_W'(pop);
      credit_used = CRD_W'(occ_q) + CRD_W'(inflight_q) - CRD_W'(pop);
      issue       = (state_q == S_READ) && (credit_used < CRD_W'(FIFO_DEPTH));
      last_addr   = (rd_row_q == LAST_ROW) && (rd_col_q == LAST_COL);
      head_row    = fifo_row_q[rd_ptr_q];
      head_col    = fifo_col_q[rd_ptr_q];
   end

   always_comb begin
      state_d  = state_q;
      rd_row_d = rd_row_q;
      rd_col_d = rd_col_q;
      case (state_q)
         S_IDLE:  if (bus_io.start && !bus_io.abort) state_d = S_READ;
         S_READ:  if (bus_io.abort) state_d = S_IDLE;
                  else if (issue && last_addr) state_d = S_DRAIN;
         // Leave DRAIN as soon as the FIFO is about to be empty so done follows the last transfer.
         S_DRAIN: if (bus_io.abort) state_d = S_IDLE;
                  else if (occ_d == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus_io.abort || state_q == S_IDLE) begin
         rd_row_d = '0;
         rd_col_d = '0;
      end else if (issue) begin
         if (last_addr) begin
            rd_row_d = '0;
            rd_col_d = '0;
         end else if (rd_col_q == LAST_COL) begin
            rd_row_d = rd_row_q + ROW_W'(1);
            rd_col_d = '0;
         end else begin
            rd_col_d = rd_col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_row_q   <= '0;
         rd_col_q   <= '0;
         pend_row_q <= '0;
         pend_col_q <= '0;
         inflight_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
      end else begin
         state_q  <= state_d;
         rd_row_q <= rd_row_d;
         rd_col_q <= rd_col_d;
         if (issue) begin
            pend_row_q <= rd_row_q;
            pend_col_q <= rd_col_q;
         end
         if (bus_io.abort) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
         end else begin
            inflight_q <= issue;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q <= occ_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= bus_io.c_rdata;
         fifo_row_q[wr_ptr_q]  <= pend_row_q;
         fifo_col_q[wr_ptr_q]  <= pend_col_q;
      end
   end

   // Head fields are forced to zero when empty so every output is 0 in reset and idle.
   assign bus_io.c_re      = issue;
   assign bus_io.c_rrow    = issue ? rd_row_q : '0;
   assign bus_io.c_rcol    = issue ? rd_col_q : '0;
   assign bus_io.out_valid = !empty;
   assign bus_io.out_data  = empty ? '0 : fifo_data_q[rd_ptr_q];
   assign bus_io.out_row   = empty ? '0 : head_row;
   assign bus_io.out_col   = empty ? '0 : head_col;
   assign bus_io.out_eol   = !empty && (head_col == LAST_COL);
   assign bus_io.out_last  = !empty && (head_col == LAST_COL) && (head_row == LAST_ROW);
   assign bus_io.busy      = (state_q == S_READ) || (state_q == S_DRAIN);
   assign bus_io.done      = (state_q == S_DONE);
   assign state_o          = state_q;
endmodule

// File: tb/tb_c_tile_reader.sv
// Bench for c_tile_reader: an 8x8 instance with a control vector table, a stream
// scoreboard and random backpressure, plus a 1x3 instance for the degenerate shape.
module tb_c_tile_reader;
   localparam int M  = 8;
   localparam int N  = 8;
   localparam int DW = 32;
   localparam int FD = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   c_tile_reader_if #(.M(M), .N(N), .DATA_W(DW)) m_if ();
   c_tile_reader_if #(.M(1), .N(3), .DATA_W(DW)) s_if ();
   logic [1:0] m_state, s_state;

   c_tile_reader #(.M(M), .N(N), .DATA_W(DW), .FIFO_DEPTH(FD)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus_io(m_if.master), .state_o(m_state));
   c_tile_reader #(.M(1), .N(3), .DATA_W(DW), .FIFO_DEPTH(FD)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .bus_io(s_if.master), .state_o(s_state));

   // ---------------- C SRAM models (junk when not read) ----------------
   logic [DW-1:0] mem   [M*N];
   logic [DW-1:0] mem_s [4];
   always @(posedge clk) m_if.c_rdata <= m_if.c_re ? mem[{m_if.c_rrow, m_if.c_rcol}] : $urandom;
   always @(posedge clk) s_if.c_rdata <= s_if.c_re ? mem_s[s_if.c_rcol] : $urandom;

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- ready driver: 0 manual, 1 always, 2 random 30% ----------------
   int ready_mode = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) m_if.out_ready = 1'b1;
      else if (ready_mode == 2) m_if.out_ready = ($urandom_range(0, 99) < 30);
   end

   // ---------------- scoreboard / reference model for the 8x8 stream ----------------
   bit            mon_en = 1'b0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_d;
   int            rd_cnt, hs_cnt, done_cnt, first_hs_cyc, last_hs_cyc, mon_idx;
   int            cyc = 0;
   bit            done_exp, stall_prev, hs;
   logic [DW-1:0] prev_data;
   logic [2:0]    prev_row, prev_col;

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         hs = m_if.out_valid && m_if.out_ready;
         if (stall_prev)
            chk("stable", 64'({m_if.out_valid, m_if.out_row, m_if.out_col, m_if.out_data}),
                64'({1'b1, prev_row, prev_col, prev_data}));
         // Outstanding = reads issued minus elements taken, including this cycle's transfer.
         if (m_if.c_re) begin
            chk("issue", 64'({(rd_cnt - hs_cnt - int'(hs)) < FD, rd_cnt < M*N, m_if.c_rrow, m_if.c_rcol}),
                64'({1'b1, 1'b1, 3'(rd_cnt / N), 3'(rd_cnt % N)}));
            rd_cnt++;
         end
         if (hs) begin
            chk("element_expected", 64'(exp_q.size() > 0), 64'd1);
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            mon_idx = hs_cnt;
            chk($sformatf("elem%0d", mon_idx),
                64'({m_if.out_data, m_if.out_row, m_if.out_col, m_if.out_eol, m_if.out_last}),
                64'({exp_d, 3'(mon_idx / N), 3'(mon_idx % N), (mon_idx % N) == N-1, mon_idx == M*N-1}));
            if (hs_cnt == 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            hs_cnt++;
         end
         chk("done", 64'(m_if.done), 64'(done_exp));
         if (m_if.done) done_cnt++;
         done_exp   = hs && (hs_cnt == M*N);
         stall_prev = m_if.out_valid && !m_if.out_ready;
         prev_data  = m_if.out_data;
         prev_row   = m_if.out_row;
         prev_col   = m_if.out_col;
         if (m_if.abort) begin
            exp_q.delete();
            rd_cnt = 0;
            hs_cnt = 0;
            done_exp = 1'b0;
            stall_prev = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_tile();
      exp_q.delete();
      for (int i = 0; i < M*N; i++) exp_q.push_back(mem[i]);
      rd_cnt = 0; hs_cnt = 0; done_cnt = 0; done_exp = 1'b0; stall_prev = 1'b0;
      @(posedge clk); #1 m_if.start = 1'b1;
      @(posedge clk); #1 m_if.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(name, 64'(done_cnt != 0), 64'd1);
   endtask

   task automatic wait_hs(input int target, input string name);
      int k;
      k = 0;
      while (hs_cnt < target && k < 1000) begin
         @(posedge clk);
         k++;
      end
      chk(name, 64'(hs_cnt), 64'(target));
   endtask

   function automatic logic [63:0] m_outs();
      return 64'({m_if.busy, m_if.done, m_if.c_re, m_if.c_rrow, m_if.c_rcol, m_if.out_valid,
                  m_if.out_data, m_if.out_row, m_if.out_col, m_if.out_eol, m_if.out_last});
   endfunction

   // ---------------- control vector table ----------------
   typedef struct packed {
      logic          start;
      logic          abort;
      logic          ready;
      logic          busy;
      logic          c_re;
      logic          valid;
      logic          done;
      logic [DW-1:0] data;
   } vec_t;
   vec_t vecs [14];

   // ---------------- main sequence ----------------
   initial begin
      int n, sdone;
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1000};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1000};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1000};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1001};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd1001};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};

      m_if.start = 1'b0; m_if.abort = 1'b0; m_if.out_ready = 1'b0;
      s_if.start = 1'b0; s_if.abort = 1'b0; s_if.out_ready = 1'b0;
      for (int i = 0; i < M*N; i++) mem[i] = 1000 + i;
      mem_s[0] = 5; mem_s[1] = 6; mem_s[2] = 7; mem_s[3] = 0;

      repeat (3) @(posedge clk);
      #1 chk("reset_outs", m_outs(), 64'd0);
      @(negedge clk) rst_n = 1'b1;

      // Control table: abort beats start in IDLE, latency, credit stall, ignored start, abort.
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         m_if.start = vecs[i].start;
         m_if.abort = vecs[i].abort;
         m_if.out_ready = vecs[i].ready;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 64'({m_if.busy, m_if.c_re, m_if.out_valid, m_if.done, m_if.out_data}),
             64'({vecs[i].busy, vecs[i].c_re, vecs[i].valid, vecs[i].done, vecs[i].data}));
      end
      @(posedge clk); #1;
      m_if.start = 1'b0; m_if.abort = 1'b0; m_if.out_ready = 1'b0;

      // T1: asynchronous reset while READ holds 3 FIFO entries.
      @(posedge clk); #1 m_if.start = 1'b1;
      @(posedge clk); #1 m_if.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 chk("t1_pre", 64'({m_if.busy, m_if.out_valid}), 64'(2'b11));
      rst_n = 1'b0;
      #1 chk("t1_reset_outs", m_outs(), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) chk("t1_idle", m_outs(), 64'd0);

      // T2: full speed, C[i][j] = i*8+j.
      for (int i = 0; i < M*N; i++) mem[i] = i;
      mon_en = 1'b1;
      ready_mode = 1;
      start_tile();
      @(negedge clk) chk("t2_lat_e0", 64'({m_if.busy, m_if.c_re, m_if.out_valid}), 64'(3'b110));
      @(negedge clk) chk("t2_lat_e1", 64'({m_if.busy, m_if.c_re, m_if.out_valid}), 64'(3'b110));
      @(negedge clk) chk("t2_lat_e2", 64'({m_if.busy, m_if.c_re, m_if.out_valid}), 64'(3'b111));
      wait_done(200, "t2_done_seen");
      chk("t2_count", 64'(hs_cnt), 64'(M*N));
      chk("t2_burst", 64'(last_hs_cyc - first_hs_cyc), 64'(M*N - 1));
      repeat (3) @(posedge clk);
      chk("t2_one_done", 64'(done_cnt), 64'd1);

      // T3: random data, ready high 30% of cycles.
      for (int i = 0; i < M*N; i++) mem[i] = $urandom;
      ready_mode = 2;
      start_tile();
      wait_done(4000, "t3_done_seen");
      repeat (3) @(posedge clk);
      chk("t3_count", 64'(hs_cnt), 64'(M*N));
      chk("t3_one_done", 64'(done_cnt), 64'd1);

      // T4: abort after 10 elements, then a fresh tile.
      for (int i = 0; i < M*N; i++) mem[i] = i;
      ready_mode = 1;
      start_tile();
      wait_hs(10, "t4_hs_before_abort");
      ready_mode = 0;
      #1 m_if.out_ready = 1'b0;
      m_if.abort = 1'b1;
      @(posedge clk); #1 m_if.abort = 1'b0;
      m_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         @(negedge clk) chk("t4_idle", 64'({m_if.busy, m_if.out_valid, m_if.done}), 64'd0);
      chk("t4_no_done", 64'(done_cnt), 64'd0);
      ready_mode = 1;
      start_tile();
      wait_done(200, "t4_done_seen");
      repeat (3) @(posedge clk);
      chk("t4_count", 64'(hs_cnt), 64'(M*N));

      // T5: second start mid-tile is ignored.
      start_tile();
      wait_hs(20, "t5_reach20");
      #1 m_if.start = 1'b1;
      @(posedge clk); #1 m_if.start = 1'b0;
      wait_done(200, "t5_done_seen");
      for (int i = 0; i < 5; i++)
         @(negedge clk) chk("t5_idle", 64'({m_if.busy, m_if.out_valid}), 64'd0);
      chk("t5_count", 64'(hs_cnt), 64'(M*N));
      chk("t5_one_done", 64'(done_cnt), 64'd1);
      mon_en = 1'b0;

      // T6: M=1, N=3 tile [5,6,7].
      s_if.out_ready = 1'b1;
      @(posedge clk); #1 s_if.start = 1'b1;
      @(posedge clk); #1 s_if.start = 1'b0;
      n = 0;
      sdone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (s_if.out_valid && s_if.out_ready) begin
            chk($sformatf("t6_elem%0d", n),
                64'({s_if.out_data, s_if.out_row, s_if.out_col, s_if.out_eol, s_if.out_last}),
                64'({32'(5 + n), 1'b0, 2'(n), n == 2, n == 2}));
            n++;
         end
         if (s_if.done) sdone++;
      end
      chk("t6_count", 64'(n), 64'd3);
      chk("t6_one_done", 64'(sdone), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
